// File: rtl/stream_demux_n_pkg.sv
// Shared constants for the N-way stream demux: well-known CHDR UDP ports,
// the DROP select encoding and the packet-framing state type.
package stream_demux_n_pkg;

  localparam logic [15:0] CHDR_PORT_CTRL = 16'd49200;
  localparam logic [15:0] CHDR_PORT_TX   = 16'd49202;
  localparam logic [15:0] CHDR_PORT_RX   = 16'd49204;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } demuxState_e;

  // Select width must hold every output index plus one extra DROP code.
  function automatic int selWidth(input int numOut);
    return (numOut < 1) ? 1 : $clog2(numOut + 1);
  endfunction

  function automatic int dropCode(input int numOut);
    return numOut;
  endfunction

endpackage

// File: rtl/stream_demux_match.sv
// Combinational key lookup: compares the port key against every PORT_LIST
// entry and returns the lowest matching index, or the DROP code.
module stream_demux_match
  import stream_demux_n_pkg::*;
#(
  parameter int                          USER_W    = 16,
  parameter int                          NUM_OUT   = 3,
  parameter int                          SEL_W     = 2,
  parameter logic [NUM_OUT*USER_W-1:0]   PORT_LIST = '0
) (
  input  logic [USER_W-1:0] i_key,
  output logic [SEL_W-1:0]  o_sel
);

  logic [SEL_W-1:0] w_sel;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    w_sel = SEL_W'(dropCode(NUM_OUT));
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (i_key == PORT_LIST[i*USER_W +: USER_W]) begin
        w_sel = SEL_W'(i);
      end
    end
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/stream_demux_n.sv
// N-way AXI-Stream packet demux keyed on tuser; unmatched packets are consumed
// and counted. Routing is decided on the first beat with zero added latency.
module stream_demux_n
  import stream_demux_n_pkg::*;
#(
  parameter int                        CHDR_W    = 64,
  parameter int                        USER_W    = 16,
  parameter int                        NUM_OUT   = 3,
  parameter logic [NUM_OUT*USER_W-1:0] PORT_LIST = {CHDR_PORT_RX, CHDR_PORT_TX, CHDR_PORT_CTRL},
  parameter logic [NUM_OUT-1:0]        DROP_LIST = '0,
  parameter int                        CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [CHDR_W-1:0]           i_tdata,
  input  logic [USER_W-1:0]           i_tuser,
  input  logic                        i_tlast,
  input  logic                        i_tvalid,
  output logic                        i_tready,
  output logic [NUM_OUT*CHDR_W-1:0]   o_tdata,
  output logic [NUM_OUT-1:0]          o_tlast,
  output logic [NUM_OUT-1:0]          o_tvalid,
  input  logic [NUM_OUT-1:0]          o_tready,
  output logic [NUM_OUT*CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int               SEL_W    = selWidth(NUM_OUT);
  localparam logic [SEL_W-1:0] DROP_SEL = SEL_W'(dropCode(NUM_OUT));

  demuxState_e                       r_state;
  logic [SEL_W-1:0]                  r_sel;
  logic [NUM_OUT-1:0][CNT_W-1:0]     r_pktCnt;
  logic [CNT_W-1:0]                  r_dropCnt;

  logic [SEL_W-1:0]   w_matchSel;
  logic [SEL_W-1:0]   w_route;
  logic [NUM_OUT-1:0] w_oValid;
  logic               w_iReady;
  logic               w_active;
  logic               w_hs;

  stream_demux_match #(
    .USER_W    (USER_W),
    .NUM_OUT   (NUM_OUT),
    .SEL_W     (SEL_W),
    .PORT_LIST (PORT_LIST)
  ) u_match (
    .i_key (i_tuser),
    .o_sel (w_matchSel)
  );

  assign w_route  = (r_state == ST_MID) ? r_sel : w_matchSel;
  assign w_active = reset_n & ~clear;

  // Sinks and DROP swallow beats; reset and clear hold everything quiet.
  always_comb begin
    w_oValid = '0;
    w_iReady = 1'b0;
    if (w_route == DROP_SEL) begin
      w_iReady = 1'b1;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_route == SEL_W'(i)) begin
          if (DROP_LIST[i]) begin
            w_iReady = 1'b1;
          end else begin
            w_iReady    = o_tready[i];
            w_oValid[i] = i_tvalid;
          end
        end
      end
    end
    if (!w_active) begin
      w_oValid = '0;
      w_iReady = 1'b0;
    end
  end

  assign w_hs = i_tvalid & w_iReady;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FIRST;
      r_sel   <= '0;
    end else if (clear) begin
      r_state <= ST_FIRST;
      r_sel   <= '0;
    end else if (w_hs) begin
      if (i_tlast) begin
        r_state <= ST_FIRST;
      end else if (r_state == ST_FIRST) begin
        r_state <= ST_MID;
        r_sel   <= w_route;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pktCnt  <= '0;
      r_dropCnt <= '0;
    end else if (clear) begin
      r_pktCnt  <= '0;
      r_dropCnt <= '0;
    end else if (w_hs && i_tlast) begin
      if (w_route == DROP_SEL) begin
        r_dropCnt <= r_dropCnt + CNT_W'(1);
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_route == SEL_W'(i)) begin
          r_pktCnt[i] <= r_pktCnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_tdata  = {NUM_OUT{i_tdata}};
  assign o_tlast  = {NUM_OUT{i_tlast}};
  assign o_tvalid = w_oValid;
  assign i_tready = w_iReady;
  assign pkt_cnt  = r_pktCnt;
  assign drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed self-checking bench for stream_demux_n; output 2 is configured as a
// sink so the sink path can be exercised alongside normal and DROP routing.
module tb_stream_demux_n;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic [63:0]   i_tdata;
  logic [15:0]   i_tuser;
  logic          i_tlast;
  logic          i_tvalid;
  logic          i_tready;
  logic [191:0]  o_tdata;
  logic [2:0]    o_tlast;
  logic [2:0]    o_tvalid;
  logic [2:0]    o_tready;
  logic [95:0]   pkt_cnt;
  logic [31:0]   drop_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  stream_demux_n #(
    .CHDR_W    (64),
    .USER_W    (16),
    .NUM_OUT   (3),
    .PORT_LIST ({16'd49204, 16'd49202, 16'd49200}),
    .DROP_LIST (3'b100),
    .CNT_W     (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tuser  (i_tuser),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge, then settle to the falling edge.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [15:0] u,
                               input logic l, input logic [2:0] rdy);
    i_tvalid = v;
    i_tdata  = d;
    i_tuser  = u;
    i_tlast  = l;
    o_tready = rdy;
    @(negedge clk);
  endtask

  task automatic advanceClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = 64'h0;
    i_tuser  = 16'd49200;
    i_tlast  = 1'b0;
    o_tready = 3'b111;
    #2;
    checkOutput("reset_o_tvalid", 64'(o_tvalid), 64'h0);
    checkOutput("reset_i_tready", 64'(i_tready), 64'h0);
    checkOutput("reset_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h0);
    checkOutput("reset_drop_cnt", 64'(drop_cnt), 64'h0);
    advanceClock();
    reset_n  = 1'b1;
    i_tvalid = 1'b0;

    // 4-beat packet to output 0, presented in the very first cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'h100 + 64'(k), 16'd49200, (k == 3), 3'b111);
      checkOutput($sformatf("t1_valid_b%0d", k), 64'(o_tvalid), 64'h1);
      checkOutput($sformatf("t1_ready_b%0d", k), 64'(i_tready), 64'h1);
      checkOutput($sformatf("t1_data_b%0d", k), o_tdata[63:0], 64'h100 + 64'(k));
      advanceClock();
    end
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b111);
    checkOutput("t1_idle_valid", 64'(o_tvalid), 64'h0);
    checkOutput("t1_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h1);
    checkOutput("t1_last_bcast", 64'(o_tlast), 64'h0);
    advanceClock();

    // Output 1 with toggling ready; second beat carries a different key.
    applyStimulus(1'b1, 64'h200, 16'd49202, 1'b0, 3'b111);
    checkOutput("t2_valid_c0", 64'(o_tvalid), 64'h2);
    checkOutput("t2_ready_c0", 64'(i_tready), 64'h1);
    advanceClock();
    applyStimulus(1'b1, 64'h201, 16'd49200, 1'b1, 3'b101);
    checkOutput("t2_valid_c1", 64'(o_tvalid), 64'h2);
    checkOutput("t2_ready_c1", 64'(i_tready), 64'h0);
    checkOutput("t2_data_c1", o_tdata[127:64], 64'h201);
    checkOutput("t2_last_c1", 64'(o_tlast), 64'h7);
    advanceClock();
    applyStimulus(1'b1, 64'h201, 16'd49200, 1'b1, 3'b111);
    checkOutput("t2_valid_c2", 64'(o_tvalid), 64'h2);
    checkOutput("t2_ready_c2", 64'(i_tready), 64'h1);
    advanceClock();
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b101);
    checkOutput("t2_valid_c3", 64'(o_tvalid), 64'h0);
    checkOutput("t2_pkt_cnt1", 64'(pkt_cnt[63:32]), 64'h1);
    advanceClock();

    // Unmatched key with all outputs stalled: consumed and counted as dropped.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 64'h300 + 64'(k), 16'd1234, (k == 4), 3'b000);
      checkOutput($sformatf("t3_ready_b%0d", k), 64'(i_tready), 64'h1);
      checkOutput($sformatf("t3_valid_b%0d", k), 64'(o_tvalid), 64'h0);
      advanceClock();
    end
    applyStimulus(1'b1, 64'h3ff, 16'd49200, 1'b1, 3'b111);
    checkOutput("t3_drop_cnt", 64'(drop_cnt), 64'h1);
    checkOutput("t3_next_valid", 64'(o_tvalid), 64'h1);
    advanceClock();
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b000);
    checkOutput("t3_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h2);
    advanceClock();

    // Output 2 is a sink: consumed despite o_tready=0, never presented.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 64'h400 + 64'(k), 16'd49204, (k == 2), 3'b000);
      checkOutput($sformatf("t4_ready_b%0d", k), 64'(i_tready), 64'h1);
      checkOutput($sformatf("t4_valid_b%0d", k), 64'(o_tvalid), 64'h0);
      advanceClock();
    end
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b111);
    checkOutput("t4_pkt_cnt2", 64'(pkt_cnt[95:64]), 64'h1);
    checkOutput("t4_drop_cnt", 64'(drop_cnt), 64'h1);
    advanceClock();

    // Clear blocks the input for its cycle and zeroes every counter.
    clear = 1'b1;
    applyStimulus(1'b1, 64'h500, 16'd49200, 1'b1, 3'b111);
    checkOutput("clr_ready", 64'(i_tready), 64'h0);
    advanceClock();
    clear = 1'b0;
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b111);
    checkOutput("clr_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h0);
    checkOutput("clr_pkt_cnt2", 64'(pkt_cnt[95:64]), 64'h0);
    checkOutput("clr_drop_cnt", 64'(drop_cnt), 64'h0);
    advanceClock();

    // Back-to-back single-beat packets, one per cycle.
    applyStimulus(1'b1, 64'h600, 16'd49200, 1'b1, 3'b111);
    checkOutput("t5_valid_p0", 64'(o_tvalid), 64'h1);
    advanceClock();
    applyStimulus(1'b1, 64'h601, 16'd49202, 1'b1, 3'b111);
    checkOutput("t5_valid_p1", 64'(o_tvalid), 64'h2);
    checkOutput("t5_ready_p1", 64'(i_tready), 64'h1);
    advanceClock();
    applyStimulus(1'b1, 64'h602, 16'd49200, 1'b1, 3'b111);
    checkOutput("t5_valid_p2", 64'(o_tvalid), 64'h1);
    advanceClock();
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b111);
    checkOutput("t5_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h2);
    checkOutput("t5_pkt_cnt1", 64'(pkt_cnt[63:32]), 64'h1);
    checkOutput("t5_pkt_cnt2", 64'(pkt_cnt[95:64]), 64'h0);
    advanceClock();

    // Async reset on beat 2 of a packet to output 0.
    applyStimulus(1'b1, 64'h700, 16'd49200, 1'b0, 3'b111);
    advanceClock();
    applyStimulus(1'b1, 64'h701, 16'd49202, 1'b0, 3'b111);
    checkOutput("t6_mid_valid", 64'(o_tvalid), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(o_tvalid), 64'h0);
    checkOutput("t6_rst_ready", 64'(i_tready), 64'h0);
    checkOutput("t6_rst_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h0);
    checkOutput("t6_rst_pkt_cnt1", 64'(pkt_cnt[63:32]), 64'h0);
    advanceClock();
    reset_n = 1'b1;
    applyStimulus(1'b1, 64'h800, 16'd49202, 1'b1, 3'b111);
    checkOutput("t6_post_valid", 64'(o_tvalid), 64'h2);
    checkOutput("t6_post_data", o_tdata[127:64], 64'h800);
    advanceClock();
    applyStimulus(1'b0, 64'h0, 16'd0, 1'b0, 3'b111);
    checkOutput("t6_post_pkt_cnt1", 64'(pkt_cnt[63:32]), 64'h1);
    checkOutput("t6_post_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
